// File: rtl/bin_loader_pkg.sv
// Shared definitions for the BIN-format tape loader: FSM states, frame
// constants and a frame classifier used by the parser.
package bin_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEADER,
        ST_HI,
        ST_LO,
        ST_WRITE,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        FR_LEADER,
        FR_FIELD,
        FR_ORIGIN,
        FR_DATA,
        FR_BAD
    } frame_class_t;

    localparam logic [7:0] FRAME_LEADER = 8'h80;
    localparam logic [7:0] FIELD_MASK   = 8'hC0;
    localparam logic [7:0] ORIGIN_MASK  = 8'h40;

    // 0x81-0xBF have no meaning in a BIN tape and are reported as malformed
    function automatic frame_class_t classify(input logic [7:0] b);
        if (b == FRAME_LEADER)
            return FR_LEADER;
        else if ((b & FIELD_MASK) == FIELD_MASK)
            return FR_FIELD;
        else if (b[7])
            return FR_BAD;
        else if ((b & ORIGIN_MASK) != 8'h00)
            return FR_ORIGIN;
        else
            return FR_DATA;
    endfunction

endpackage

// File: rtl/bin_checksum.sv
// 12-bit running tape checksum with a compare that excludes the last word's
// own two frames (the last word on a BIN tape is the checksum itself).
module bin_checksum (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        add,
    input  logic [7:0]  value,
    input  logic [11:0] word,
    output logic        mismatch
);

    logic [11:0] sum;

    // accumulate accepted frame values modulo 4096
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            sum <= '0;
        else if (clear)
            sum <= '0;
        else if (add)
            sum <= sum + {4'b0000, value};
    end

    // word is only ever a data word, so its frames are {00,word[11:6]} and {00,word[5:0]}
    always_comb begin
        mismatch = ((sum - {6'b000000, word[11:6]} - {6'b000000, word[5:0]}) != word);
    end

endmodule

// File: rtl/bin_loader.sv
// PDP-8 BIN tape loader: parses host frames into 12-bit words and writes them
// into program RAM port B, holding each data word back one word so the final
// (checksum) word is never written.
module bin_loader
    import bin_loader_pkg::*;
#(
    parameter int AMSB = 9,
    parameter int DMSB = 11
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [7:0]      in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic            mem_we,
    output logic [AMSB:0]   mem_addr,
    output logic [DMSB:0]   mem_din,
    output logic            busy,
    output logic            done,
    output logic            cksum_err,
    output logic            fmt_err
);

    state_t         state;
    frame_class_t   cls;
    logic [AMSB:0]  addr;
    logic [5:0]     hi_bits;
    logic           hi_origin;
    logic [DMSB:0]  pending;
    logic           pending_valid;
    logic [DMSB:0]  word;
    logic           fire;
    logic           sum_add;
    logic           sum_clear;
    logic           mismatch;

    assign in_ready = (state == ST_LEADER) || (state == ST_HI) || (state == ST_LO);

    // frame decode and checksum control for the current handshake
    always_comb begin
        cls       = classify(in_data);
        fire      = in_valid && in_ready;
        word      = {hi_bits, in_data[5:0]};
        sum_clear = start && ((state == ST_IDLE) || (state == ST_DONE));
        sum_add   = 1'b0;
        if (fire) begin
            if ((state == ST_LEADER) || (state == ST_HI))
                sum_add = (cls == FR_ORIGIN) || (cls == FR_DATA);
            else if (state == ST_LO)
                sum_add = (cls == FR_DATA);
        end
    end

    bin_checksum u_checksum (
        .clk      (clk),
        .reset    (reset),
        .clear    (sum_clear),
        .add      (sum_add),
        .value    (in_data),
        .word     (pending),
        .mismatch (mismatch)
    );

    // load sequencer with registered status and RAM write outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            addr          <= '0;
            hi_bits       <= '0;
            hi_origin     <= 1'b0;
            pending       <= '0;
            pending_valid <= 1'b0;
            mem_we        <= 1'b0;
            mem_addr      <= '0;
            mem_din       <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            cksum_err     <= 1'b0;
            fmt_err       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state         <= ST_LEADER;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        cksum_err     <= 1'b0;
                        fmt_err       <= 1'b0;
                        pending_valid <= 1'b0;
                    end
                end
                // LEADER and HI share high-frame handling; only HI treats 0x80 as trailer
                ST_LEADER, ST_HI: begin
                    if (fire) begin
                        case (cls)
                            FR_LEADER: begin
                                if (state == ST_HI) begin
                                    cksum_err     <= !pending_valid || mismatch;
                                    pending_valid <= 1'b0;
                                    done          <= 1'b1;
                                    busy          <= 1'b0;
                                    state         <= ST_DONE;
                                end
                            end
                            FR_FIELD: state <= ST_HI;
                            FR_ORIGIN, FR_DATA: begin
                                hi_bits   <= in_data[5:0];
                                hi_origin <= (cls == FR_ORIGIN);
                                state     <= ST_LO;
                            end
                            default: begin
                                fmt_err       <= 1'b1;
                                pending_valid <= 1'b0;
                                done          <= 1'b1;
                                busy          <= 1'b0;
                                state         <= ST_DONE;
                            end
                        endcase
                    end
                end
                ST_LO: begin
                    if (fire) begin
                        if (cls != FR_DATA) begin
                            fmt_err       <= 1'b1;
                            pending_valid <= 1'b0;
                            done          <= 1'b1;
                            busy          <= 1'b0;
                            state         <= ST_DONE;
                        end else begin
                            // commit the previous word, then either re-origin or hold the new one
                            if (pending_valid) begin
                                mem_we   <= 1'b1;
                                mem_addr <= addr;
                                mem_din  <= pending;
                            end
                            if (hi_origin) begin
                                addr          <= word[AMSB:0];
                                pending_valid <= 1'b0;
                            end else begin
                                if (pending_valid)
                                    addr <= addr + 1'b1;
                                pending       <= word;
                                pending_valid <= 1'b1;
                            end
                            state <= ST_WRITE;
                        end
                    end
                end
                ST_WRITE: state <= ST_HI;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_loader.sv
// Directed bench for bin_loader: plays BIN tapes and checks RAM writes and status.
module tb_bin_loader;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        mem_we;
    logic [9:0]  mem_addr;
    logic [11:0] mem_din;
    logic        busy;
    logic        done;
    logic        cksum_err;
    logic        fmt_err;

    int unsigned total = 0;
    int unsigned bad = 0;

    logic [7:0]  tape[$];
    logic [9:0]  wa[$];
    logic [11:0] wd[$];

    bin_loader #(.AMSB(9), .DMSB(11)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .busy      (busy),
        .done      (done),
        .cksum_err (cksum_err),
        .fmt_err   (fmt_err)
    );

    always #5 clk = ~clk;

    // capture every RAM write in the middle of its cycle
    always @(negedge clk) begin
        if (mem_we) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_din);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // in_valid stays high across bytes so WRITE back-pressure is exercised
    task automatic send(input logic [7:0] b);
        int unsigned n;
        n = 0;
        in_data  = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("rdy_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic play_tape();
        for (int i = 0; i < tape.size(); i++) send(tape[i]);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int unsigned n;
        n = 0;
        @(negedge clk);
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!done) check("done_timeout", {31'd0, done}, 32'd1);
    endtask

    task automatic check_tape1(input string tag, input logic exp_ck);
        check({tag, "_done"}, {31'd0, done}, 32'd1);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_ck"}, {31'd0, cksum_err}, {31'd0, exp_ck});
        check({tag, "_fmt"}, {31'd0, fmt_err}, 32'd0);
        check({tag, "_nw"}, wa.size(), 32'd2);
        if (wa.size() == 2) begin
            check({tag, "_a0"}, {22'd0, wa[0]}, 32'h080);
            check({tag, "_d0"}, {20'd0, wd[0]}, 32'h123);
            check({tag, "_a1"}, {22'd0, wa[1]}, 32'h081);
            check({tag, "_d1"}, {20'd0, wd[1]}, 32'hABC);
        end
    endtask

    initial begin
        // reset state
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_we", {31'd0, mem_we}, 32'd0);
        check("rst_rdy", {31'd0, in_ready}, 32'd0);
        check("rst_err", {30'd0, cksum_err, fmt_err}, 32'd0);
        @(posedge clk); #1 reset = 1'b0;

        // tape 1: good checksum
        wa.delete(); wd.delete();
        do_start();
        check("t1_busy_start", {31'd0, busy}, 32'd1);
        tape = '{8'h80, 8'h80, 8'h80, 8'h42, 8'h00, 8'h04, 8'h23, 8'h2A, 8'h3C, 8'h03, 8'h0F, 8'h80};
        play_tape();
        wait_done();
        check_tape1("t1", 1'b0);
        check("t1_rdy_done", {31'd0, in_ready}, 32'd0);

        // tape 2: corrupted checksum word
        wa.delete(); wd.delete();
        do_start();
        check("t2_done_clr", {31'd0, done}, 32'd0);
        tape = '{8'h80, 8'h42, 8'h00, 8'h04, 8'h23, 8'h2A, 8'h3C, 8'h03, 8'h0E, 8'h80};
        play_tape();
        wait_done();
        check_tape1("t2", 1'b1);

        // tape 3: origin 0x3FF, address wraps to 0x000
        wa.delete(); wd.delete();
        do_start();
        tape = '{8'h80, 8'h4F, 8'h3F, 8'h00, 8'h01, 8'h00, 8'h02, 8'h02, 8'h11, 8'h80};
        play_tape();
        wait_done();
        check("t3_ck", {31'd0, cksum_err}, 32'd0);
        check("t3_nw", wa.size(), 32'd2);
        if (wa.size() == 2) begin
            check("t3_a0", {22'd0, wa[0]}, 32'h3FF);
            check("t3_d0", {20'd0, wd[0]}, 32'h001);
            check("t3_a1", {22'd0, wa[1]}, 32'h000);
            check("t3_d1", {20'd0, wd[1]}, 32'h002);
        end

        // tape 4: field bytes between words are ignored and not summed
        wa.delete(); wd.delete();
        do_start();
        tape = '{8'h80, 8'h42, 8'h00, 8'hC8, 8'h04, 8'h23, 8'hC8, 8'h2A, 8'h3C, 8'h03, 8'h0F, 8'h80};
        play_tape();
        wait_done();
        check_tape1("t4", 1'b0);

        // tape 5: 0x80 in the low frame position is malformed
        wa.delete(); wd.delete();
        do_start();
        tape = '{8'h80, 8'h42, 8'h00, 8'h04, 8'h23, 8'h2A, 8'h80};
        play_tape();
        wait_done();
        check("t5_fmt", {31'd0, fmt_err}, 32'd1);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_ck", {31'd0, cksum_err}, 32'd0);
        check("t5_nw", wa.size(), 32'd0);

        // tape 6: reset lands in the WRITE cycle of the first commit, then a clean reload
        wa.delete(); wd.delete();
        do_start();
        tape = '{8'h80, 8'h42, 8'h00, 8'h04, 8'h23, 8'h2A, 8'h3C};
        play_tape();
        check("t6_we_before", {31'd0, mem_we}, 32'd1);
        #1 reset = 1'b1;
        #1;
        check("t6_we_rst", {31'd0, mem_we}, 32'd0);
        check("t6_busy_rst", {31'd0, busy}, 32'd0);
        check("t6_addr_rst", {22'd0, mem_addr}, 32'd0);
        repeat (2) @(negedge clk);
        check("t6_nw_rst", wa.size(), 32'd0);
        @(posedge clk); #1 reset = 1'b0;
        do_start();
        tape = '{8'h80, 8'h80, 8'h42, 8'h00, 8'h04, 8'h23, 8'h2A, 8'h3C, 8'h03, 8'h0F, 8'h80};
        play_tape();
        wait_done();
        check_tape1("t6", 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
